// File: rtl/seg_mem_wb_elastic.sv
// MEM/WB elastic pipeline segment: valid/ready handshake, flush, falling-edge state.
// Build macro SEG_MEM_WB_SKID_EN selects the two-entry skid buffer; otherwise a single register.
module seg_mem_wb_elastic #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int FLAG_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              FlagsWriteM,
  input  logic [FLAG_W-1:0] ALUFlagsM,
  input  logic [ADDR_W-1:0] WA3M,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] ALUOutM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              FlagsWriteW,
  output logic [FLAG_W-1:0] ALUFlagsW,
  output logic [ADDR_W-1:0] WA3W,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [DATA_W-1:0] ResultW,
  output logic              fwd_valid,
  output logic [1:0]        occupancy
);

  localparam int REC_W = 3 + FLAG_W + ADDR_W + 2 * DATA_W;
  localparam int RW_B  = REC_W - 1;
  localparam int FW_B  = REC_W - 3;

  logic [REC_W-1:0] in_rec;
  logic [REC_W-1:0] m_rec;
  logic             accept_ev;
  logic             release_ev;

  assign in_rec     = {RegWriteM, MemtoRegM, FlagsWriteM, ALUFlagsM, WA3M, ReadDataM, ALUOutM};
  assign accept_ev  = in_valid & in_ready;
  assign release_ev = out_valid & out_ready;

`ifdef SEG_MEM_WB_SKID_EN
  // state | meaning
  // EMPTY | nothing held, occupancy 0
  // ONE   | M holds the head entry
  // FULL  | M holds the head, S holds the next entry; upstream stalled
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [REC_W-1:0] s_rec;
  logic             in_ready_q;
  logic             load_m_in, load_m_s, load_s, drop_ctl;

  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    drop_ctl  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept_ev) begin
          state_nxt = ONE;
          load_m_in = 1'b1;
        end
        ONE: begin
          if (accept_ev && !release_ev) begin
            state_nxt = FULL;
            load_s    = 1'b1;
          end else if (accept_ev) begin
            load_m_in = 1'b1;
          end else if (release_ev) begin
            state_nxt = EMPTY;
            drop_ctl  = 1'b1;
          end
        end
        FULL: if (release_ev) begin
          state_nxt = ONE;
          load_m_s  = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      m_rec      <= '0;
      s_rec      <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (flush) begin
        m_rec <= '0;
        s_rec <= '0;
      end else begin
        if (load_m_in) m_rec <= in_rec;
        else if (load_m_s) m_rec <= s_rec;
        else if (drop_ctl) begin
          // keep payload visible but make the write enables safe once the head leaves
          m_rec[RW_B] <= 1'b0;
          m_rec[FW_B] <= 1'b0;
        end
        if (load_s) s_rec <= in_rec;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state[0] | state[1];
  assign occupancy = state;
`else
  logic m_valid;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_rec   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_rec   <= '0;
    end else if (accept_ev) begin
      m_valid <= 1'b1;
      m_rec   <= in_rec;
    end else if (release_ev) begin
      m_valid     <= 1'b0;
      m_rec[RW_B] <= 1'b0;
      m_rec[FW_B] <= 1'b0;
    end
  end

  assign in_ready  = ~m_valid | out_ready;
  assign out_valid = m_valid;
  assign occupancy = {1'b0, m_valid};
`endif

  assign {RegWriteW, MemtoRegW, FlagsWriteW, ALUFlagsW, WA3W, ReadDataW, ALUOutW} = m_rec;
  assign ResultW   = MemtoRegW ? ReadDataW : ALUOutW;
  assign fwd_valid = out_valid & RegWriteW;

endmodule

// File: tb/tb_seg_mem_wb_elastic.sv
// Scoreboard bench for seg_mem_wb_elastic; works in both the skid and direct builds.
module tb_seg_mem_wb_elastic;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        RegWriteM = 1'b0, MemtoRegM = 1'b0, FlagsWriteM = 1'b0;
  logic [1:0]  ALUFlagsM = '0;
  logic [3:0]  WA3M = '0;
  logic [31:0] ReadDataM = '0, ALUOutM = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        RegWriteW, MemtoRegW, FlagsWriteW;
  logic [1:0]  ALUFlagsW;
  logic [3:0]  WA3W;
  logic [31:0] ReadDataW, ALUOutW, ResultW;
  logic        fwd_valid;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic        rw, mtr, fw;
    logic [1:0]  fl;
    logic [3:0]  wa;
    logic [31:0] rd, alu;
  } ent_t;

  ent_t sb[$];
  int   errors = 0, checks = 0, pops = 0;
  int   occ_max = 0;

`ifdef SEG_MEM_WB_SKID_EN
  localparam int OCC_FULL = 2;
`else
  localparam int OCC_FULL = 1;
`endif

  seg_mem_wb_elastic dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .FlagsWriteM(FlagsWriteM),
    .ALUFlagsM(ALUFlagsM), .WA3M(WA3M), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .FlagsWriteW(FlagsWriteW),
    .ALUFlagsW(ALUFlagsW), .WA3W(WA3W), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .ResultW(ResultW), .fwd_valid(fwd_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor samples one time unit before each falling (active) edge.
  always @(posedge clk) begin
    ent_t e;
    #4;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_empty_pop", 64'(out_valid), 64'(0));
        else begin
          e = sb.pop_front();
          pops++;
          chk("head_alu", 64'(ALUOutW), 64'(e.alu));
          chk("head_rd", 64'(ReadDataW), 64'(e.rd));
          chk("head_wa3", 64'(WA3W), 64'(e.wa));
          chk("head_ctl", 64'({RegWriteW, MemtoRegW, FlagsWriteW, ALUFlagsW}),
              64'({e.rw, e.mtr, e.fw, e.fl}));
          chk("head_result", 64'(ResultW), 64'(e.mtr ? e.rd : e.alu));
          chk("head_fwd", 64'(fwd_valid), 64'(e.rw));
        end
      end
      if (!out_valid) chk("gate", 64'({RegWriteW, FlagsWriteW, fwd_valid}), 64'(0));
      if (in_valid && in_ready) begin
        e.rw = RegWriteM; e.mtr = MemtoRegM; e.fw = FlagsWriteM; e.fl = ALUFlagsM;
        e.wa = WA3M; e.rd = ReadDataM; e.alu = ALUOutM;
        sb.push_back(e);
      end
    end
  end

  // Present an entry and hold it until the handshake will complete on the next falling edge.
  task automatic send(input logic rw, input logic mtr, input logic fw, input logic [1:0] fl,
                      input logic [3:0] wa, input logic [31:0] rd, input logic [31:0] alu,
                      output int waits);
    waits = 0;
    @(negedge clk); #1;
    in_valid = 1'b1; RegWriteM = rw; MemtoRegM = mtr; FlagsWriteM = fw;
    ALUFlagsM = fl; WA3M = wa; ReadDataM = rd; ALUOutM = alu;
    @(posedge clk); #1;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 50) chk("send_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("drain_timeout", 64'(out_valid), 64'(0));
  endtask

  initial begin
    int w, p0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_w", 64'({RegWriteW, MemtoRegW, FlagsWriteW, fwd_valid, ALUFlagsW, WA3W}), 64'(0));
    chk("rst_result", 64'(ResultW), 64'(0));
    #9 reset = 1'b0;

    // back-to-back stream, one edge of latency
    p0 = pops;
    out_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 2'b01, 4'd1, 32'hA0, 32'd1, w);
    chk("lat_pre", 64'(out_valid), 64'(0));
    for (int i = 2; i <= 8; i++) begin
      send(1'b1, 1'b0, 1'b0, 2'(i), 4'(i), 32'hA0 + 32'(i), 32'(i), w);
      chk("b2b_wait", 64'(w), 64'(0));
      chk("b2b_head", 64'({out_valid, fwd_valid, ALUOutW}), 64'({2'b11, 32'(i - 1)}));
    end
    idle();
    drain();
    chk("b2b_count", 64'(pops - p0), 64'(8));

    // backpressure: drop out_ready for 3 cycles mid-stream
    p0 = pops;
    fork
      for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 1'b1, 2'b10, 4'(i + 8), 32'h0, 32'h11 + 32'(i), w);
      begin
        repeat (3) @(negedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
`ifdef SEG_MEM_WB_SKID_EN
          if (out_valid) chk("stall_ready", 64'(in_ready), 64'(occupancy != 2'd2));
`else
          if (out_valid) chk("stall_ready", 64'(in_ready), 64'(0));
`endif
          @(negedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle();
    drain();
    chk("bp_count", 64'(pops - p0), 64'(8));
    chk("bp_occ_max", 64'(occ_max), 64'(OCC_FULL));

    // result mux, then gating of held control bits
    send(1'b1, 1'b1, 1'b1, 2'b11, 4'd5, 32'h1234, 32'h5678, w);
    send(1'b1, 1'b0, 1'b1, 2'b11, 4'd6, 32'h1234, 32'h5678, w);
    chk("result_mem", 64'(ResultW), 64'(32'h1234));
    idle();
    @(posedge clk); #1;
    chk("result_alu", 64'(ResultW), 64'(32'h5678));
    drain();
    chk("gate_held", 64'({out_valid, RegWriteW, FlagsWriteW}), 64'(0));

    // flush priority over accept and release
    out_ready = 1'b0;
    send(1'b1, 1'b0, 1'b1, 2'b01, 4'd9, 32'h0, 32'h77, w);
`ifdef SEG_MEM_WB_SKID_EN
    send(1'b1, 1'b0, 1'b1, 2'b01, 4'd10, 32'h0, 32'h78, w);
`endif
    @(negedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; ALUOutM = 32'hDEAD; RegWriteM = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_pre_occ", 64'(occupancy), 64'(OCC_FULL));
    @(negedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", 64'({out_valid, occupancy, RegWriteW}), 64'(0));
    chk("flush_payload", 64'(ALUOutW), 64'(0));
    repeat (3) @(posedge clk);
    #1 chk("flush_no_dead", 64'(out_valid), 64'(0));

`ifndef SEG_MEM_WB_SKID_EN
    // direct build: in_ready follows out_ready combinationally
    out_ready = 1'b0;
    send(1'b1, 1'b0, 1'b0, 2'b00, 4'd3, 32'h0, 32'h31, w);
    idle();
    @(posedge clk); #1;
    chk("dir_stall", 64'({out_valid, in_ready}), 64'(2'b10));
    in_valid = 1'b1; ALUOutM = 32'h32; WA3M = 4'd4; out_ready = 1'b1;
    #1 chk("dir_comb_ready", 64'(in_ready), 64'(1));
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("dir_same_edge", 64'({out_valid, occupancy, ALUOutW}), 64'({1'b1, 2'd1, 32'h32}));
    drain();
`endif

    // asynchronous reset mid-stream with the segment full
    out_ready = 1'b0;
    send(1'b1, 1'b1, 1'b1, 2'b11, 4'd7, 32'hBEEF, 32'h41, w);
`ifdef SEG_MEM_WB_SKID_EN
    send(1'b1, 1'b1, 1'b1, 2'b11, 4'd8, 32'hBEEF, 32'h42, w);
`endif
    idle();
    @(posedge clk); #1;
    chk("rst_pre_occ", 64'(occupancy), 64'(OCC_FULL));
    #1 reset = 1'b1;
    #1;
    chk("arst_flags", 64'({out_valid, in_ready, occupancy, fwd_valid}), 64'(5'b01000));
    chk("arst_w", 64'({RegWriteW, MemtoRegW, FlagsWriteW, ALUFlagsW, WA3W}), 64'(0));
    chk("arst_data", 64'({ReadDataW, ALUOutW}), 64'(0));
    chk("arst_result", 64'(ResultW), 64'(0));
    @(negedge clk); #2 reset = 1'b0;
    out_ready = 1'b1;

    // short stream after reset
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b0, 2'b00, 4'(i), 32'h900 + 32'(i), 32'h0, w);
    idle();
    drain();
    chk("sb_left", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
